// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern player.
//   state_e     : player states IDLE / RUN / DONE
//   ROM_AW      : pattern ROM address width ({page, step})
//   PER_W       : width of the step-period datapath
//   step_period : step period in clk cycles, base << fsel
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ROM_AW = 5;
  localparam int unsigned PER_W  = 16;

  function automatic logic [PER_W-1:0] step_period(input int unsigned base,
                                                   input logic [2:0]  fsel);
    return PER_W'(base) << fsel;
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: counts enabled cycles and flags the last cycle of
// each step period.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : force count to zero
//   en         : count enable
//   period     : step period in cycles (>= 1)
//   tick       : high when count == period-1 and en is set
module led_step_prescaler
  import led_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == period - 1'b1);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Sequenced playback controller for the 32x8 LED pattern ROM.
//   clk, reset : clock, asynchronous active-low reset
//   start/stop : begin playback (from IDLE) / abort (highest priority)
//   fsel       : rate select, step period = BASE_DIV << fsel
//   psel_req   : requested page, applied in IDLE and at pass boundaries
//   alt_en     : toggle page after every completed pass
//   rep_cnt    : passes to play, 0 = forever
//   mem_addr   : ROM address {page, step}
//   step_en    : one-cycle ROM read strobe
//   busy       : high in RUN
//   done       : one-cycle pulse at normal completion
//   loop_cnt   : completed passes since start (wraps)
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int unsigned STEP_W   = ROM_AW - 1,
  parameter int unsigned BASE_DIV = 2,
  parameter int unsigned REP_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        fsel,
  input  logic              psel_req,
  input  logic              alt_en,
  input  logic [REP_W-1:0]  rep_cnt,
  output logic [STEP_W:0]   mem_addr,
  output logic              step_en,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  loop_cnt
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                page_q, page_d;
  logic [2:0]          fsel_q, fsel_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic                alt_q, alt_d;
  logic [REP_W-1:0]    loop_q, loop_d;
  logic                step_en_q, step_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [PER_W-1:0]    period;
  logic                tick;

  assign period = step_period(BASE_DIV, fsel_q);

  // Count only in RUN; holding it clear elsewhere makes every pass start
  // from a zero prescaler without extra start/stop handling.
  led_step_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q != RUN),
    .en     (state_q == RUN),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    page_d    = page_q;
    fsel_d    = fsel_q;
    rep_d     = rep_q;
    alt_d     = alt_q;
    loop_d    = loop_q;
    step_en_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        step_d = '0;
        page_d = psel_req;
        if (start && !stop) begin
          fsel_d    = fsel;
          rep_d     = rep_cnt;
          alt_d     = alt_en;
          loop_d    = '0;
          state_d   = RUN;
          step_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        if (stop) begin
          state_d = IDLE;
          step_d  = '0;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (step_q != '1) begin
            step_d    = step_q + 1'b1;
            step_en_d = 1'b1;
            fsel_d    = fsel;
          end else begin
            loop_d = loop_q + 1'b1;
            if ((rep_q != '0) && (loop_d == rep_q)) begin
              state_d = DONE;
              step_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              step_d    = '0;
              step_en_d = 1'b1;
              page_d    = alt_q ? ~page_q : psel_req;
              fsel_d    = fsel;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      page_q    <= 1'b0;
      fsel_q    <= '0;
      rep_q     <= '0;
      alt_q     <= 1'b0;
      loop_q    <= '0;
      step_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      page_q    <= page_d;
      fsel_q    <= fsel_d;
      rep_q     <= rep_d;
      alt_q     <= alt_d;
      loop_q    <= loop_d;
      step_en_q <= step_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr = {page_q, step_q};
  assign step_en  = step_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign loop_cnt = loop_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl (BASE_DIV = 2). Stimulus pushes the
// expected strobe/done events (cycle relative to start, address or
// loop_cnt); a negedge monitor pops and compares each event the DUT shows.
module tb_led_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [2:0] fsel;
  logic       psel_req;
  logic       alt_en;
  logic [3:0] rep_cnt;
  logic [4:0] mem_addr;
  logic       step_en;
  logic       busy;
  logic       done;
  logic [3:0] loop_cnt;

  led_seq_ctrl #(.STEP_W(4), .BASE_DIV(2), .REP_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .fsel     (fsel),
    .psel_req (psel_req),
    .alt_en   (alt_en),
    .rep_cnt  (rep_cnt),
    .mem_addr (mem_addr),
    .step_en  (step_en),
    .busy     (busy),
    .done     (done),
    .loop_cnt (loop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int start_edge = 0;

  typedef struct {
    bit is_done;
    int cyc;
    int val;
  } exp_t;

  exp_t sb[$];

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input bit d, input int c, input int v);
    exp_t e;
    e.is_done = d;
    e.cyc     = c;
    e.val     = v;
    sb.push_back(e);
  endtask

  task automatic observe(input bit d, input int v);
    int cyc;
    exp_t e;
    cyc = edge_cnt - start_edge + 1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL event: got %s at cycle %0d val=%0d, expected no event",
               d ? "done" : "strobe", cyc, v);
    end else begin
      e = sb.pop_front();
      if (e.is_done != d || e.cyc != cyc || e.val != v) begin
        bad++;
        $display("FAIL event: got %s cyc=%0d val=%0d, expected %s cyc=%0d val=%0d",
                 d ? "done" : "strobe", cyc, v,
                 e.is_done ? "done" : "strobe", e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (step_en) observe(1'b0, int'(mem_addr));
      if (done)    observe(1'b1, int'(loop_cnt));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns into cycle 1 of the new run.
  task automatic do_start(input logic [2:0] f, input bit p, input bit a,
                          input logic [3:0] r);
    fsel     = f;
    psel_req = p;
    alt_en   = a;
    rep_cnt  = r;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_edge = edge_cnt;
  endtask

  task automatic push_pass(input int first, input int per, input int page);
    for (int k = 0; k < 16; k++) expect_ev(1'b0, first + k * per, page * 16 + k);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_addr"}, int'(mem_addr), 0);
    check({tag, " step_en"},  int'(step_en),  0);
    check({tag, " busy"},     int'(busy),     0);
    check({tag, " done"},     int'(done),     0);
    check({tag, " loop_cnt"}, int'(loop_cnt), 0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    fsel     = 3'd0;
    psel_req = 1'b1;
    alt_en   = 1'b1;
    rep_cnt  = 4'd5;
    #12;
    check_all_zero("reset");
    #10;
    reset = 1'b1;
    wait_cyc(1);
    check("idle page follow 1", int'(mem_addr), 16);
    psel_req = 1'b0;
    wait_cyc(1);
    check("idle page follow 0", int'(mem_addr), 0);

    // Basic pass, page 1, P=2; start during DONE must be ignored
    do_start(3'd0, 1'b1, 1'b0, 4'd1);
    push_pass(1, 2, 1);
    expect_ev(1'b1, 33, 1);
    wait_cyc(31);
    check("t1 busy cyc32", int'(busy), 1);
    wait_cyc(1);
    check("t1 busy cyc33", int'(busy), 0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    drain("t1 events", 20);
    wait_cyc(5);
    check("t1 loop_cnt", int'(loop_cnt), 1);
    check("t1 busy idle", int'(busy), 0);

    // Rate: P=8; start and psel_req changes mid-pass have no effect
    do_start(3'd2, 1'b0, 1'b0, 4'd1);
    push_pass(1, 8, 0);
    expect_ev(1'b1, 129, 1);
    wait_cyc(19);
    start    = 1'b1;
    psel_req = 1'b1;
    wait_cyc(1);
    start    = 1'b0;
    drain("t2 events", 200);
    psel_req = 1'b0;
    check("t2 loop_cnt", int'(loop_cnt), 1);

    // Alternation: page toggles against psel_req=0
    wait_cyc(2);
    do_start(3'd0, 1'b0, 1'b1, 4'd2);
    push_pass(1, 2, 0);
    push_pass(33, 2, 1);
    expect_ev(1'b1, 65, 2);
    drain("t3 events", 100);
    check("t3 loop_cnt", int'(loop_cnt), 2);

    // Abort at cycle 11, then restart
    wait_cyc(3);
    do_start(3'd0, 1'b0, 1'b0, 4'd1);
    check("t4 loop_cnt cleared", int'(loop_cnt), 0);
    for (int k = 0; k < 6; k++) expect_ev(1'b0, 1 + 2 * k, k);
    wait_cyc(10);
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
    check("t4 busy", int'(busy), 0);
    check("t4 step_en", int'(step_en), 0);
    check("t4 mem_addr", int'(mem_addr), 0);
    drain("t4 events", 5);
    wait_cyc(40);
    do_start(3'd0, 1'b0, 1'b0, 4'd1);
    check("t4 restart loop_cnt", int'(loop_cnt), 0);
    push_pass(1, 2, 0);
    expect_ev(1'b1, 33, 1);
    drain("t4 restart events", 50);

    // Infinite mode: page switch only at pass boundary, loop_cnt wraps
    wait_cyc(3);
    do_start(3'd0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; 1 + 2 * k <= 520; k++)
      expect_ev(1'b0, 1 + 2 * k, ((k >= 16) ? 16 : 0) + (k % 16));
    wait_cyc(9);
    psel_req = 1'b1;
    wait_cyc(490);
    check("t5 loop_cnt cyc500", int'(loop_cnt), 15);
    wait_cyc(14);
    check("t5 loop_cnt wrapped", int'(loop_cnt), 0);
    check("t5 busy", int'(busy), 1);
    wait_cyc(6);
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
    drain("t5 events", 10);
    psel_req = 1'b0;
    wait_cyc(4);

    // Asynchronous reset in cycle 20, then a fresh run
    do_start(3'd0, 1'b1, 1'b0, 4'd1);
    for (int k = 0; k < 10; k++) expect_ev(1'b0, 1 + 2 * k, 16 + k);
    wait_cyc(19);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("t6 async reset");
    check("t6 events before reset", sb.size(), 0);
    sb.delete();
    #3;
    reset = 1'b1;
    psel_req = 1'b0;
    wait_cyc(1);
    do_start(3'd0, 1'b0, 1'b0, 4'd1);
    push_pass(1, 2, 0);
    expect_ev(1'b1, 33, 1);
    drain("t6 events", 50);
    check("t6 loop_cnt", int'(loop_cnt), 1);

    wait_cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
